// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache serving memory-stage
// loads and stores; read misses fill over a simple request/response memory bus.
module data_cache_responder #(
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  access_size,
  output logic [63:0] read_data,
  output logic        data_valid,
  output logic        write_complete,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_write,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data
);
  localparam int unsigned BEATS = LINE_BYTES / 8;
  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 64 - OFF_W - IDX_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WRITE_REQ, WRITE_WAIT, RESPOND
  } state_t;

  state_t r_state, w_next;

  logic [63:0]          r_addr;
  logic [63:0]          r_wdata;
  logic [2:0]           r_size;
  logic                 r_is_write;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [63:0]          r_line [NUM_LINES][BEATS];
  logic [63:0]          r_read_data;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [CNT_W-1:0] w_beat;
  logic [2:0]       w_lane;
  logic             w_hit;
  logic             w_last_beat;
  logic [63:0]      w_dword;
  logic [63:0]      w_load_src;
  logic [63:0]      w_shifted;
  logic [63:0]      w_load_ext;
  logic [63:0]      w_wdata_sized;
  logic [63:0]      w_wdata_lane;
  logic [63:0]      w_merged;
  logic [7:0]       w_strb_base;
  logic [7:0]       w_strb;

  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[63 -: TAG_W];
  assign w_beat = CNT_W'(r_addr[OFF_W-1:0] >> 3);

  always_comb begin
    case (r_size[1:0])
      2'd0:    w_lane = r_addr[2:0];
      2'd1:    w_lane = {r_addr[2:1], 1'b0};
      2'd2:    w_lane = {r_addr[2], 2'b00};
      default: w_lane = 3'b000;
    endcase
  end

  always_comb begin
    case (r_size[1:0])
      2'd0:    begin w_strb_base = 8'h01; w_wdata_sized = {56'd0, r_wdata[7:0]};  end
      2'd1:    begin w_strb_base = 8'h03; w_wdata_sized = {48'd0, r_wdata[15:0]}; end
      2'd2:    begin w_strb_base = 8'h0F; w_wdata_sized = {32'd0, r_wdata[31:0]}; end
      default: begin w_strb_base = 8'hFF; w_wdata_sized = r_wdata;                end
    endcase
  end

  assign w_strb       = w_strb_base << w_lane;
  assign w_wdata_lane = w_wdata_sized << {w_lane, 3'b000};

  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_dword     = r_line[w_idx][w_beat];
  assign w_last_beat = (r_state == FILL_WAIT) && mem_resp_valid && (r_cnt == CNT_W'(BEATS - 1));
  // On the final fill beat the requested dword may still be on the bus, not yet in the array.
  assign w_load_src  = ((r_state == FILL_WAIT) && (w_beat == r_cnt)) ? mem_resp_data : w_dword;
  assign w_shifted   = w_load_src >> {w_lane, 3'b000};

  always_comb begin
    case (r_size)
      3'b000:  w_load_ext = {{56{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load_ext = {56'd0, w_shifted[7:0]};
      3'b101:  w_load_ext = {48'd0, w_shifted[15:0]};
      3'b110:  w_load_ext = {32'd0, w_shifted[31:0]};
      default: w_load_ext = w_shifted;
    endcase
  end

  always_comb begin
    w_merged = w_dword;
    for (int unsigned b = 0; b < 8; b++) begin
      if (w_strb[b]) w_merged[b*8 +: 8] = w_wdata_lane[b*8 +: 8];
    end
  end

  always_comb begin
    w_next         = r_state;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_wstrb  = '0;
    data_valid     = 1'b0;
    write_complete = 1'b0;
    case (r_state)
      IDLE: if (read_enable || write_enable) w_next = LOOKUP;
      LOOKUP: begin
        if (r_is_write)  w_next = WRITE_REQ;
        else if (w_hit)  w_next = RESPOND;
        else             w_next = FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_addr[63:OFF_W], {OFF_W{1'b0}}};
        if (mem_req_ready) w_next = FILL_WAIT;
      end
      FILL_WAIT: if (w_last_beat) w_next = RESPOND;
      WRITE_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {r_addr[63:3], 3'b000};
        mem_req_wdata = w_wdata_lane;
        mem_req_wstrb = w_strb;
        if (mem_req_ready) w_next = WRITE_WAIT;
      end
      WRITE_WAIT: if (mem_resp_valid) w_next = RESPOND;
      RESPOND: begin
        data_valid     = !r_is_write;
        write_complete = r_is_write;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign read_data = r_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_is_write  <= 1'b0;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && (read_enable || write_enable)) begin
        r_addr     <= address;
        r_wdata    <= write_data;
        r_size     <= access_size;
        r_is_write <= write_enable;
      end
      if ((r_state == FILL_WAIT) && mem_resp_valid) r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
      if (w_last_beat) r_valid[w_idx] <= 1'b1;
      if (((r_state == LOOKUP) && !r_is_write && w_hit) || w_last_beat) r_read_data <= w_load_ext;
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is cached.
  always_ff @(posedge clk) begin
    if ((r_state == FILL_WAIT) && mem_resp_valid) r_line[w_idx][r_cnt] <= mem_resp_data;
    if (w_last_beat) r_tag[w_idx] <= w_tag;
    if ((r_state == LOOKUP) && r_is_write && w_hit) r_line[w_idx][w_beat] <= w_merged;
  end
endmodule

// File: tb/tb_data_cache_responder.sv
// Directed bench for data_cache_responder: a vector table drives requests against a
// bench-side backing memory, plus hand sequences for reset mid-fill and stalls.
module tb_data_cache_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  access_size;
  logic [63:0] read_data;
  logic        data_valid;
  logic        write_complete;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_write;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  data_cache_responder #(.NUM_LINES(64), .LINE_BYTES(64)) dut (
    .clk(clk), .reset(reset), .address(address), .write_data(write_data),
    .read_enable(read_enable), .write_enable(write_enable), .access_size(access_size),
    .read_data(read_data), .data_valid(data_valid), .write_complete(write_complete),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_write(mem_req_write), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    int          stall;
    int          hs;
    int          lat;
    logic [63:0] rd;
    logic [63:0] req_addr;
    logic [7:0]  strb;
    logic [63:0] req_wdata;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] bmem [logic [63:0]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] bmem_rd(input logic [63:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 64'hA5A5_0000_0000_0000 | a;
  endfunction

  task automatic bmem_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] t;
    t = bmem_rd(a);
    for (int b = 0; b < 8; b++) if (s[b]) t[b*8 +: 8] = d[b*8 +: 8];
    bmem[a] = t;
  endtask

  // Called #1 after an edge with the DUT idle; plays requester and backing memory.
  task automatic run_req(input string tag, input vec_t v, output logic [63:0] rd, output int cyc,
                         output int nhs, output logic [63:0] ra, output logic [7:0] rs,
                         output logic [63:0] rw);
    bit armed, ack_pend, seen, done, s_wr;
    int beats_left, beat_no, stall_left;
    logic [63:0] line;
    armed = 0; ack_pend = 0; seen = 0; done = 0; s_wr = 0;
    beats_left = 0; beat_no = 0; stall_left = v.stall; line = '0;
    rd = '0; cyc = 0; nhs = 0; ra = '0; rs = '0; rw = '0;
    address = v.addr; write_data = v.wdata; access_size = v.size;
    write_enable = v.wr; read_enable = !v.wr;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (armed) begin
        armed = 0;
        mem_req_ready = 1'b0;
        check({tag, "_req_drop"}, 64'(mem_req_valid), 64'd0);
        if (s_wr) ack_pend = 1;
        else begin beats_left = 8; beat_no = 0; line = ra; end
      end
      mem_resp_valid = 1'b0;
      if (data_valid || write_complete) begin
        check({tag, "_pulse"}, 64'({data_valid, write_complete}), v.wr ? 64'd1 : 64'd2);
        rd = read_data;
        done = 1;
      end else begin
        if (beats_left > 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = bmem_rd(line + 64'(8 * beat_no));
          beat_no++;
          beats_left--;
        end else if (ack_pend) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
          ack_pend = 0;
        end
        if (mem_req_valid) begin
          if (seen) begin
            check({tag, "_hold_addr"},  mem_req_addr,  ra);
            check({tag, "_hold_wdata"}, mem_req_wdata, rw);
            check({tag, "_hold_wstrb"}, 64'(mem_req_wstrb), 64'(rs));
          end else begin
            seen = 1; ra = mem_req_addr; rw = mem_req_wdata; rs = mem_req_wstrb; s_wr = mem_req_write;
          end
          if (stall_left > 0) stall_left--;
          else begin
            mem_req_ready = 1'b1;
            armed = 1;
            nhs++;
            if (s_wr) bmem_wr(ra, rw, rs);
          end
        end
      end
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk); #1;
    check({tag, "_single_pulse"}, 64'({data_valid, write_complete}), 64'd0);
    read_enable = 1'b0; write_enable = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [63:0] rd, ra, rw;
    logic [7:0]  rs;
    int          cyc, nhs;
    run_req(tag, v, rd, cyc, nhs, ra, rs, rw);
    check({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    check({tag, "_handshakes"}, 64'(nhs), 64'(v.hs));
    if (!v.wr) check({tag, "_read_data"}, rd, v.rd);
    if (v.hs > 0) check({tag, "_req_addr"}, ra, v.req_addr);
    if (v.wr) begin
      check({tag, "_wstrb"}, 64'(rs), 64'(v.strb));
      check({tag, "_wdata"}, rw, v.req_wdata);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 64'({mem_req_valid, mem_req_write, data_valid, write_complete}), 64'd0);
    check({tag, "_read_data"}, read_data, 64'd0);
    check({tag, "_req_fields"}, mem_req_addr | mem_req_wdata | 64'(mem_req_wstrb), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          wr    addr         sz    wdata                   stl hs lat rd                      req_addr     strb   req_wdata
    vt[0]  = '{1'b0, 64'h1000, 3'd3, 64'h0,                   0, 1, 11, 64'h11,                  64'h1000, 8'h00, 64'h0};
    vt[1]  = '{1'b0, 64'h1008, 3'd3, 64'h0,                   0, 0,  2, 64'h22,                  64'h0,    8'h00, 64'h0};
    vt[2]  = '{1'b1, 64'h1010, 3'd3, 64'h80FF,                0, 1,  4, 64'h0,                   64'h1010, 8'hFF, 64'h80FF};
    vt[3]  = '{1'b0, 64'h1011, 3'd0, 64'h0,                   0, 0,  2, 64'hFFFFFFFF_FFFFFF80,   64'h0,    8'h00, 64'h0};
    vt[4]  = '{1'b0, 64'h1011, 3'd4, 64'h0,                   0, 0,  2, 64'h80,                  64'h0,    8'h00, 64'h0};
    vt[5]  = '{1'b0, 64'h1010, 3'd1, 64'h0,                   0, 0,  2, 64'hFFFFFFFF_FFFF80FF,   64'h0,    8'h00, 64'h0};
    vt[6]  = '{1'b1, 64'h1012, 3'd1, 64'hBEEF,                0, 1,  4, 64'h0,                   64'h1010, 8'h0C, 64'h00000000_BEEF0000};
    vt[7]  = '{1'b0, 64'h1012, 3'd5, 64'h0,                   0, 0,  2, 64'hBEEF,                64'h0,    8'h00, 64'h0};
    vt[8]  = '{1'b0, 64'h1010, 3'd3, 64'h0,                   0, 0,  2, 64'h00000000_BEEF80FF,   64'h0,    8'h00, 64'h0};
    vt[9]  = '{1'b1, 64'h3004, 3'd2, 64'hFFFFFFFF_12345678,   0, 1,  4, 64'h0,                   64'h3000, 8'hF0, 64'h12345678_00000000};
    vt[10] = '{1'b0, 64'h3000, 3'd3, 64'h0,                   0, 1, 11, 64'h12345678_00003000,   64'h3000, 8'h00, 64'h0};
    vt[11] = '{1'b0, 64'h3006, 3'd5, 64'h0,                   0, 0,  2, 64'h1234,                64'h0,    8'h00, 64'h0};
    vt[12] = '{1'b0, 64'h2000, 3'd3, 64'h0,                   0, 1, 11, 64'hA5A50000_00002000,   64'h2000, 8'h00, 64'h0};
    vt[13] = '{1'b0, 64'h1000, 3'd3, 64'h0,                   0, 1, 11, 64'h11,                  64'h1000, 8'h00, 64'h0};
    vt[14] = '{1'b0, 64'h1038, 3'd2, 64'h0,                   0, 0,  2, 64'h88,                  64'h0,    8'h00, 64'h0};
    vt[15] = '{1'b0, 64'h2008, 3'd3, 64'h0,                   5, 1, 16, 64'hA5A50000_00002008,   64'h2000, 8'h00, 64'h0};
    vt[16] = '{1'b1, 64'h2009, 3'd0, 64'h7E,                  5, 1,  9, 64'h0,                   64'h2008, 8'h02, 64'h7E00};
    vt[17] = '{1'b0, 64'h2009, 3'd0, 64'h0,                   0, 0,  2, 64'h7E,                  64'h0,    8'h00, 64'h0};
    vt[18] = '{1'b0, 64'h4038, 3'd3, 64'h0,                   0, 1, 11, 64'hA5A50000_00004038,   64'h4000, 8'h00, 64'h0};
    for (int k = 0; k < 8; k++) bmem[64'h1000 + 64'(8 * k)] = 64'h11 * 64'(k + 1);

    reset = 1'b1; address = '0; write_data = '0; read_enable = 1'b0; write_enable = 1'b0;
    access_size = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) check_vec($sformatf("v%0d", i), vt[i]);

    // Reset three beats into a fill of 0x5000 (index 0 currently holds 0x4000).
    address = 64'h5000; access_size = 3'd3; read_enable = 1'b1;
    for (int i = 0; i < 10 && !mem_req_valid; i++) begin @(posedge clk); #1; end
    check("midfill_req", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 64'hBAD0_0000_0000_0000 | 64'(i);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    check_quiet("midfill_reset");
    read_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_quiet($sformatf("stray_resp%0d", i));
    end
    mem_resp_valid = 1'b0;

    v = '{1'b0, 64'h1000, 3'd3, 64'h0, 0, 1, 11, 64'h11, 64'h1000, 8'h00, 64'h0};
    check_vec("post_reset_1000", v);
    v = '{1'b0, 64'h5000, 3'd3, 64'h0, 0, 1, 11, 64'hA5A50000_00005000, 64'h5000, 8'h00, 64'h0};
    check_vec("post_reset_5000", v);
    v = '{1'b0, 64'h5000, 3'd7, 64'h0, 0, 0, 2, 64'hA5A50000_00005000, 64'h0, 8'h00, 64'h0};
    check_vec("post_reset_5000_hit", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
